systolic_gemm_tile: RTL and testbench

Parametrised output-stationary systolic GEMM tile: computes C = A·B for a ROWS×K by K×COLS operand pair streamed one K-beat per handshake, with runtime K length, signed/unsigned mode, cross-tile accumulation and saturating accumulators. Input skewing is internal. Results drain row-by-row over a valid/ready stream. It supersedes the fixed-K, single-shot array as the compute core behind the matrix-engine controller.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_mac_pe.sv | 53 +++++
 rtl/systolic_gemm_tile.sv | 153 +++++++++++++++
 tb/tb_systolic_gemm_tile.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type, saturation bounds and width check for the systolic GEMM tile
package systolic_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
   localparam int MAX_ACC_WIDTH = 126;
   typedef logic signed [MAX_ACC_WIDTH+1:0] bound_t;
   // upper=1 gives the largest representable accumulator value, upper=0 the smallest
   function automatic bound_t sat_bound(input int acc_width, input logic sgn, input logic upper);
      bound_t one;
      one = bound_t'(1);
      return upper ? (one <<< (sgn ? acc_width - 1 : acc_width)) - one
                   : (sgn ? -(one <<< (acc_width - 1)) : '0);
   endfunction
   function automatic bit acc_width_ok(input int acc_width, input int data_width);
      return acc_width >= 2 * data_width && acc_width <= MAX_ACC_WIDTH;
   endfunction
endpackage

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: one output-stationary PE with operand pass-through and saturating MAC
// clk, rst_n      : clock, async active-low reset
// en, clr         : accumulate enable (else hold), clear accumulator
// signed_mode     : operand/saturation interpretation
// a_in/b_in       : operands from left/top; a_out/b_out registered copies to right/bottom
// acc, sat_hit    : accumulator value, clamp occurred on this cycle's update
module systolic_mac_pe
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic                  sat_hit
);
   localparam int PW = 2 * DATA_WIDTH + 2;
   // two spare bits hold any unsigned or signed sum before clamping
   localparam int SW = ACC_WIDTH + 2;
   logic signed [DATA_WIDTH:0] a_x, b_x;
   logic signed [PW-1:0]       prod;
   logic signed [SW-1:0]       acc_x, sum, hi, lo;
   logic [ACC_WIDTH-1:0]       nxt;
   always_comb begin
      a_x     = $signed({signed_mode & a_out[DATA_WIDTH-1], a_out});
      b_x     = $signed({signed_mode & b_out[DATA_WIDTH-1], b_out});
      prod    = PW'(a_x) * PW'(b_x);
      acc_x   = signed_mode ? SW'($signed(acc)) : SW'({1'b0, acc});
      sum     = acc_x + SW'(prod);
      hi      = SW'(sat_bound(ACC_WIDTH, signed_mode, 1'b1));
      lo      = SW'(sat_bound(ACC_WIDTH, signed_mode, 1'b0));
      nxt     = ACC_WIDTH'(sum > hi ? hi : sum < lo ? lo : sum);
      sat_hit = en && (sum > hi || sum < lo);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= clr ? '0 : en ? nxt : acc;
      end
endmodule

// File: rtl/systolic_gemm_tile.sv
// systolic_gemm_tile: output-stationary ROWSxCOLS systolic GEMM tile with internal skew and row drain
// clk, rst_n                 : clock, async active-low reset
// start, k_len, acc_mode,
// signed_mode                : tile launch (sampled in IDLE) and its latched settings
// in_valid/in_ready, a_in, b_in : one K-beat (A column, B row) per handshake
// out_valid/out_ready, out_data, out_row, out_last : result rows, one per handshake
// busy, done, sat            : not idle, end-of-tile pulse, sticky saturation flag
module systolic_gemm_tile
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int K_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [K_WIDTH-1:0]         k_len,
   input  logic                       acc_mode,
   input  logic                       signed_mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH*ROWS-1:0] a_in,
   input  logic [DATA_WIDTH*COLS-1:0] b_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_WIDTH*COLS-1:0]  out_data,
   output logic [$clog2(ROWS)-1:0]    out_row,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
   output logic                       sat
);
   localparam int RW        = $clog2(ROWS);
   localparam int FLUSH_LEN = ROWS + COLS - 1;
   if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH)) begin : g_bad_width
      $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
   end
   state_t                state, state_nxt;
   logic [K_WIDTH-1:0]    k_q, cnt, cnt_nxt;
   logic                  sgn_q, fire, take, clr, en, row_fire;
   logic [DATA_WIDTH-1:0] a_link [ROWS][COLS+1];
   logic [DATA_WIDTH-1:0] b_link [ROWS+1][COLS];
   logic [ACC_WIDTH-1:0]  acc [ROWS][COLS];
   logic [ROWS*COLS-1:0]  sat_pe;
   assign in_ready  = state == LOAD && cnt < k_q;
   assign fire      = in_valid && in_ready;
   assign take      = start && state == IDLE;
   assign clr       = take && !acc_mode;
   assign en        = state == LOAD || state == FLUSH;
   assign out_valid = state == DRAIN;
   assign out_last  = out_valid && out_row == RW'(ROWS - 1);
   assign row_fire  = out_valid && out_ready;
   assign busy      = state != IDLE;
   // cnt counts accepted beats in LOAD and elapsed cycles in FLUSH; zero on every state entry
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE:  if (start) begin
            state_nxt = k_len == '0 ? FLUSH : LOAD;
            cnt_nxt   = '0;
         end
         LOAD:  if (fire) begin
            state_nxt = cnt == k_q - 1'b1 ? FLUSH : LOAD;
            cnt_nxt   = cnt == k_q - 1'b1 ? '0 : cnt + 1'b1;
         end
         FLUSH: begin
            state_nxt = cnt == K_WIDTH'(FLUSH_LEN - 1) ? DRAIN : FLUSH;
            cnt_nxt   = cnt == K_WIDTH'(FLUSH_LEN - 1) ? '0 : cnt + 1'b1;
         end
         DRAIN: state_nxt = row_fire && out_last ? IDLE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         k_q     <= '0;
         sgn_q   <= 1'b0;
         out_row <= '0;
         done    <= 1'b0;
         sat     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         k_q     <= take ? k_len : k_q;
         sgn_q   <= take ? signed_mode : sgn_q;
         out_row <= row_fire ? (out_last ? '0 : out_row + 1'b1) : out_row;
         done    <= row_fire && out_last;
         sat     <= take ? 1'b0 : sat | (|sat_pe);
      end
   // row i of A enters i cycles late; non-handshake cycles inject zeros
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      logic [DATA_WIDTH-1:0] beat;
      assign beat = fire ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (i == 0) begin : g_direct
         assign a_link[i][0] = beat;
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] sr [i];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sr <= '{default: '0};
            else begin
               sr[0] <= beat;
               for (int d = 1; d < i; d++) sr[d] <= sr[d-1];
            end
         assign a_link[i][0] = sr[i-1];
      end
   end
   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      logic [DATA_WIDTH-1:0] beat;
      assign beat = fire ? b_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (j == 0) begin : g_direct
         assign b_link[0][j] = beat;
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] sr [j];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sr <= '{default: '0};
            else begin
               sr[0] <= beat;
               for (int d = 1; d < j; d++) sr[d] <= sr[d-1];
            end
         assign b_link[0][j] = sr[j-1];
      end
   end
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         systolic_mac_pe #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
         ) u_pe (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .clr        (clr),
            .signed_mode(sgn_q),
            .a_in       (a_link[i][j]),
            .b_in       (b_link[i][j]),
            .a_out      (a_link[i][j+1]),
            .b_out      (b_link[i+1][j]),
            .acc        (acc[i][j]),
            .sat_hit    (sat_pe[i*COLS+j])
         );
      end
   end
   always_comb begin
      out_data = '0;
      for (int j = 0; j < COLS; j++) out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[out_row][j];
   end
endmodule

// File: tb/tb_systolic_gemm_tile.sv
// tb_systolic_gemm_tile: directed checks of a 4x4 tile at 32-bit and 16-bit accumulator widths
module tb_systolic_gemm_tile;
   localparam int DW = 8, R = 4, C = 4, AW = 32, SW = 16, KW = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, acc_mode = 1'b0, signed_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [KW-1:0]   k_len = '0;
   logic [DW*R-1:0] a_in = '0;
   logic [DW*C-1:0] b_in = '0;
   logic            in_ready, out_valid, out_last, busy, done, sat;
   logic [AW*C-1:0] out_data;
   logic [1:0]      out_row;
   logic            s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_sat;
   logic [SW*C-1:0] s_out_data;
   logic [1:0]      s_out_row;
   logic [31:0]     a_b [8], b_b [8];
   logic [127:0]    exp_c [4], res [4];
   logic [63:0]     exp_s [4], res_s [4];
   int              n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   systolic_gemm_tile #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
      .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
      .out_last(out_last), .busy(busy), .done(done), .sat(sat));
   systolic_gemm_tile #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(SW), .K_WIDTH(KW)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
      .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(s_in_ready), .a_in(a_in), .b_in(b_in),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_row(s_out_row),
      .out_last(s_out_last), .busy(s_busy), .done(s_done), .sat(s_sat));
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [127:0] row4(input logic [31:0] x0, x1, x2, x3);
      return {x3, x2, x1, x0};
   endfunction
   task automatic set_identity();
      for (int k = 0; k < 8; k++) begin
         a_b[k] = '0;
         b_b[k] = '0;
      end
      a_b[0] = 32'h0000_0001; a_b[1] = 32'h0000_0100; a_b[2] = 32'h0001_0000; a_b[3] = 32'h0100_0000;
      b_b[0] = {8'd1, 8'd1, 8'd1, 8'd1};
      b_b[1] = {8'd5, 8'd4, 8'd3, 8'd2};
      b_b[2] = {8'd9, 8'd7, 8'd5, 8'd3};
      b_b[3] = {8'd13, 8'd10, 8'd7, 8'd4};
      exp_c[0] = row4(1, 1, 1, 1);
      exp_c[1] = row4(2, 3, 4, 5);
      exp_c[2] = row4(3, 5, 7, 9);
      exp_c[3] = row4(4, 7, 10, 13);
   endtask
   task automatic set_uniform(input logic [7:0] v, input logic [31:0] e, input logic [15:0] es);
      for (int k = 0; k < 8; k++) begin
         a_b[k] = {4{v}};
         b_b[k] = {4{v}};
      end
      for (int i = 0; i < 4; i++) begin
         exp_c[i] = {4{e}};
         exp_s[i] = {4{es}};
      end
   endtask
   task automatic start_tile(input int k, input bit am, input bit sm);
      start = 1'b1; k_len = KW'(k); acc_mode = am; signed_mode = sm;
      step();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("sat_cleared", {sat, s_sat}, 0);
   endtask
   task automatic feed(input int k, input bit gaps, input bit poke);
      int  n = 0, g = 0;
      bit  fire;
      while (n < k && g < 500) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         a_in = in_valid ? a_b[n] : '1;
         b_in = in_valid ? b_b[n] : '1;
         if (poke && n == 1) begin
            start = 1'b1; k_len = 1; acc_mode = 1'b0;
         end
         fire = in_valid && in_ready;
         step();
         start = 1'b0;
         g++;
         if (fire) n++;
      end
      in_valid = 1'b0; a_in = '0; b_in = '0;
      check("beats_fed", n, k);
   endtask
   task automatic wait_out();
      int lat = 0;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      check("flush_latency", lat, R + C - 1);
   endtask
   task automatic drain(input bit bp, input int nrows);
      int           row = 0, g = 0;
      bit           stall = 1'b0;
      logic [127:0] held;
      while (row < nrows && g < 200) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) check("stall_hold", out_data, held);
         check("drain_valid", out_valid, 1);
         check("drain_row", out_row, row);
         check("drain_last", out_last, row == R - 1);
         check("done_low", done, 0);
         held  = out_data;
         stall = !out_ready;
         if (out_ready) begin
            res[row]   = out_data;
            res_s[row] = s_out_data;
            row++;
         end
         step();
         g++;
      end
      out_ready = 1'b0;
      check("rows_drained", row, nrows);
      if (nrows == R) begin
         check("done_pulse", done, 1);
         check("idle_after", busy, 0);
      end
   endtask
   task automatic cmp_c(input string tag);
      for (int i = 0; i < R; i++) check($sformatf("%s_r%0d", tag, i), res[i], exp_c[i]);
   endtask
   task automatic run(input int k, input bit am, input bit sm, input bit gaps, input bit bp, input bit poke);
      start_tile(k, am, sm);
      feed(k, gaps, poke);
      wait_out();
      drain(bp, R);
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {in_ready, out_valid, out_last, busy, done, sat}, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_row"}, out_row, 0);
      check({tag, "_s_ctl"}, {s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_sat}, 0);
   endtask
   initial begin
      step();
      step();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();
      set_identity();
      run(4, 0, 1, 0, 0, 0);
      cmp_c("identity");
      set_uniform(8'hFF, 32'd2, 16'd2);
      run(2, 0, 1, 0, 0, 0);
      cmp_c("ff_signed");
      check("ff_signed_sat", sat, 0);
      set_uniform(8'hFF, 32'd130050, 16'hFFFF);
      run(2, 0, 0, 0, 0, 0);
      cmp_c("ff_unsigned");
      check("ff_unsigned_sat", sat, 0);
      set_uniform(8'd127, 32'd48387, 16'd32767);
      run(3, 0, 1, 0, 0, 0);
      cmp_c("sat_wide");
      for (int i = 0; i < R; i++) check($sformatf("sat16_r%0d", i), res_s[i], exp_s[i]);
      check("sat16_flag", s_sat, 1);
      check("sat_wide_flag", sat, 0);
      set_uniform(8'd1, 32'd5, 16'd5);
      run(5, 0, 1, 0, 0, 0);
      cmp_c("acc_tile1");
      set_uniform(8'd1, 32'd8, 16'd8);
      run(3, 1, 1, 0, 0, 0);
      cmp_c("acc_tile2");
      set_uniform(8'd1, 32'd3, 16'd3);
      run(3, 0, 1, 0, 0, 0);
      cmp_c("acc_clear");
      set_identity();
      run(4, 0, 1, 1, 1, 0);
      cmp_c("gaps_bp");
      run(0, 1, 1, 0, 0, 0);
      cmp_c("k0_held");
      set_uniform(8'd0, 32'd0, 16'd0);
      run(0, 0, 1, 0, 0, 0);
      cmp_c("k0_clear");
      set_uniform(8'd1, 32'd4, 16'd4);
      run(4, 0, 1, 0, 0, 1);
      cmp_c("start_in_load");
      set_uniform(8'd1, 32'd2, 16'd2);
      start_tile(2, 0, 1);
      feed(2, 0, 0);
      wait_out();
      drain(0, 2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_drain_rst");
      step();
      step();
      rst_n = 1'b1;
      step();
      set_uniform(8'd1, 32'd3, 16'd3);
      run(3, 1, 1, 0, 0, 0);
      cmp_c("fresh_after_rst");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
